// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial transmitter slice.
//   state_e    : frame sequencer states (IDLE, START, DATA, STOP)
//   IDLE_LEVEL : serial line level outside a frame and during the stop bit
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Divides the clock into serial bit periods of CLKS_PER_BIT cycles.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset, clears the counter
//   clear    : holds the counter at 0 (used while the line is idle)
//   bit_done : high on the last cycle of each bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_done = (cnt_q == LAST);
    cnt_d    = cnt_q + CNT_W'(1);
    // Wrap at the bit boundary so only 0..CLKS_PER_BIT-1 is ever reached.
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Parallel-to-serial frame transmitter: start bit (0), DATA_W payload bits
//   LSB first, stop bit (1), each bit held CLKS_PER_BIT clock cycles.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset, aborts any frame in progress
//   tx_data  : payload, sampled only on the accepting edge
//   tx_valid : producer request; accepted when tx_ready is high
//   tx_ready : high exactly while idle
//   tx_out   : registered serial line, idle high
//   busy     : frame in progress
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_out_q, tx_out_d;
  logic              bit_done;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so the flop presents each
    // bit starting on the same edge the state changes.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      default: tx_out_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_out_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_out_q <= tx_out_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule
